// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer and bus encoder: state encoding,
// bus endpoint indices and a one-hot helper.
package bus_sequencer_pkg;

  localparam int unsigned N_BUS_SRC = 27;
  localparam int unsigned CODE_W    = 5;

  localparam int unsigned R0_IDX  = 0;
  localparam int unsigned R15_IDX = 15;
  localparam int unsigned HI_IDX  = 16;
  localparam int unsigned LO_IDX  = 17;
  localparam int unsigned ZHI_IDX = 18;
  localparam int unsigned ZLO_IDX = 19;
  localparam int unsigned PC_IDX  = 20;
  localparam int unsigned IR_IDX  = 21;
  localparam int unsigned MDR_IDX = 22;
  localparam int unsigned IN_IDX  = 23;
  localparam int unsigned C_IDX   = 24;
  localparam int unsigned Y_IDX   = 25;
  localparam int unsigned MAR_IDX = 26;

  typedef logic [N_BUS_SRC-1:0] bus_vec_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F0   = 3'd1,
    F1   = 3'd2,
    F2   = 3'd3,
    XFER = 3'd4
  } state_t;

  // Single-bit bus vector for a fixed endpoint index.
  function automatic bus_vec_t bus_bit(input int unsigned idx);
    bus_vec_t v;
    logic [CODE_W-1:0] i;
    i = CODE_W'(idx);
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_sequencer_onehot_dec.sv
// 5-bit bus endpoint code to 27-bit one-hot; codes above 26 flag illegal
// and produce an all-zero vector.
module onehot_dec5_27
  import bus_sequencer_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output bus_vec_t          onehot_c,
  output logic              illegal_c
);

  always_comb begin
    onehot_c  = '0;
    illegal_c = (code >= CODE_W'(N_BUS_SRC));
    if (!illegal_c) onehot_c[code] = 1'b1;
  end

endmodule

// File: rtl/bus_sequencer.sv
// Instruction-fetch / register-transfer sequencer driving one-hot bus
// source enables and register load enables.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 xfer_req,
  input  logic [CODE_W-1:0]    xfer_src,
  input  logic [CODE_W-1:0]    xfer_dst,
  input  logic                 mem_ready,
  output logic [N_BUS_SRC-1:0] src_oe,
  output logic [N_BUS_SRC-1:0] dst_le,
  output logic                 inc_pc,
  output logic                 mem_read,
  output logic                 xfer_ack,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_vec_t         src_q, src_d, dst_q, dst_d;
  logic             inc_pc_d, mem_read_d, ack_d, done_d, err_d;
  bus_vec_t         src_hot, dst_hot, mdr_ld_c;
  logic             src_ill, dst_ill, xfer_ill;

  onehot_dec5_27 u_src_dec (.code(xfer_src), .onehot_c(src_hot), .illegal_c(src_ill));
  onehot_dec5_27 u_dst_dec (.code(xfer_dst), .onehot_c(dst_hot), .illegal_c(dst_ill));

  assign xfer_ill = src_ill | dst_ill;

  // Next state and the output values that go with the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = '0;
    dst_d      = '0;
    inc_pc_d   = 1'b0;
    mem_read_d = 1'b0;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = F0;
          src_d    = bus_bit(PC_IDX);
          dst_d    = bus_bit(MAR_IDX);
          inc_pc_d = 1'b1;
        end else if (xfer_req) begin
          state_d = XFER;
          src_d   = xfer_ill ? '0 : src_hot;
          dst_d   = xfer_ill ? '0 : dst_hot;
          ack_d   = 1'b1;
          err_d   = xfer_ill;
        end
      end
      F0: begin
        state_d    = F1;
        mem_read_d = 1'b1;
      end
      F1: begin
        if (mem_ready) begin
          state_d = F2;
          cnt_d   = '0;
          src_d   = bus_bit(MDR_IDX);
          dst_d   = bus_bit(IR_IDX);
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          mem_read_d = 1'b1;
        end
      end
      F2: begin
        // A transfer held pending behind a fetch is served immediately.
        if (xfer_req) begin
          state_d = XFER;
          src_d   = xfer_ill ? '0 : src_hot;
          dst_d   = xfer_ill ? '0 : dst_hot;
          ack_d   = 1'b1;
          err_d   = xfer_ill;
        end else begin
          state_d = IDLE;
        end
      end
      XFER:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      inc_pc   <= 1'b0;
      mem_read <= 1'b0;
      xfer_ack <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      inc_pc   <= inc_pc_d;
      mem_read <= mem_read_d;
      xfer_ack <= ack_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= (state_d != IDLE);
    end
  end

  // MDR captures read data in the same F1 cycle that mem_ready is valid.
  assign mdr_ld_c = (state_q == F1 && mem_ready) ? bus_bit(MDR_IDX) : '0;

  assign src_oe = src_q;
  assign dst_le = dst_q | mdr_ld_c;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  single rising-edge clock.
REQ-002 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  request an instruction-fetch sequence.
REQ-004 SHALL have port: xfer_req  in  1  request a single register transfer; level, held until xfer_ack.
REQ-005 SHALL have port: xfer_src  in  5  source code, index 0..26.
REQ-006 SHALL have port: xfer_dst  in  5  destination code, index 0..26.
REQ-007 SHALL have port: mem_ready  in  1  memory read data valid.
REQ-008 SHALL have port: src_oe  out  27  one-hot bus-drive enables; bit order R0..R15, HI, LO, ZHI, ZLO, PC, IR, MDR, IN, C, Y, MAR (bits 0..26).
REQ-009 SHALL have port: dst_le  out  27  one-hot register load enables, same bit order.
REQ-010 SHALL have ports: inc_pc, mem_read, xfer_ack, done, err  out  1 each; busy  out  1.
REQ-011 SHALL have parameter: TIMEOUT, default 255, mem_ready wait limit in cycles.

Function
REQ-012 SHALL implement states IDLE, F0, F1, F2, XFER, all outputs registered or decoded from state only (Moore).
REQ-013 In IDLE, start=1 SHALL move to F0; else xfer_req=1 SHALL latch xfer_src/xfer_dst and move to XFER.
REQ-014 start and xfer_req both high in IDLE: start SHALL win; xfer_req stays pending, served after fetch.
REQ-015 F0 (1 cycle): src_oe[PC]=1, dst_le[MAR]=1, inc_pc=1; next F1.
REQ-016 F1: mem_read=1 every cycle; wait counter increments each cycle mem_ready=0.
REQ-017 F1 with mem_ready=1: dst_le[MDR]=1 that cycle, counter cleared, next F2.
REQ-018 F1 counter reaching TIMEOUT without mem_ready: err=1 one cycle, no load, return IDLE.
REQ-019 F2 (1 cycle): src_oe[MDR]=1, dst_le[IR]=1, done=1; next IDLE.
REQ-020 XFER (1 cycle): src_oe[latched src]=1, dst_le[latched dst]=1, xfer_ack=1; next IDLE.
REQ-021 XFER with either latched code >26: src_oe=dst_le=0, err=1, xfer_ack=1; next IDLE.
REQ-022 XFER with src==dst (legal): drive both enables normally.
REQ-023 src_oe SHALL never have more than one bit set; same for dst_le.
REQ-024 busy=1 in every state except IDLE.
REQ-025 start asserted while busy SHALL be ignored (not queued).
REQ-026 Fetch latency start->done: 3 cycles plus mem_ready wait cycles.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, counter 0, latched codes 0, all outputs 0.
REQ-028 Reset mid-sequence SHALL abort without completing loads; after release, behave as power-up.

Structure
REQ-029 Shared package SHALL hold state enum and bus index constants (R0_IDX..MAR_IDX, N_BUS_SRC=27), shared with the bus encoder.
REQ-030 One sub-module SHALL be natural: onehot_dec5_27 (5-bit code -> 27-bit one-hot plus illegal flag), instantiated twice.

Verification
REQ-031 start=1, mem_ready on 2nd F1 cycle -> src_oe=PC/dst_le=MAR, then MDR load, then MDR->IR with done at cycle 4.
REQ-032 xfer_req, src=3, dst=25 -> one cycle later src_oe=0x0000008, dst_le=0x2000000, xfer_ack=1.
REQ-033 start and xfer_req same cycle -> fetch completes first, xfer_ack follows the cycle after done.
REQ-034 mem_ready held 0, TIMEOUT=4 -> err pulse after 4 F1 cycles, no MDR/IR load, busy drops.
REQ-035 xfer_src=30 -> err=1, xfer_ack=1, src_oe=dst_le=0.
REQ-036 reset_n low during F1 -> all outputs 0 immediately; next start runs a full clean fetch.
